// File: rtl/dsp_dtree_defs.sv
// rtl/dsp_dtree_defs.sv - shared encodings and field positions for the decision-tree equation
// Contents: FSM state encodings, control-word field positions, error class word,
//           input-register field positions.
package dsp_dtree_defs;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SPLIT,
    S_RD_CTRL,
    S_RD_SENSOR,
    S_COMPARE,
    S_ERR,
    S_WR_OUT,
    S_NEXT_SAMPLE,
    S_RESET_SPLIT,
    S_FINISH
  } dtree_state_e;

  typedef enum logic [1:0] {
    H_IDLE,
    H_REQ,
    H_WAIT
  } hs_state_e;

  // Control word fields
  localparam int F_DSP_DTREE_LEAF          = 31;
  localparam int F_DSP_DTREE_SENSOR_SEL_HI = 23;
  localparam int F_DSP_DTREE_SENSOR_SEL_LO = 16;
  localparam int F_DSP_DTREE_OUTPUT_HI     = 7;
  localparam int F_DSP_DTREE_OUTPUT_LO     = 0;

  // Class word written when a sample cannot be classified
  localparam logic [31:0] DSP_DTREE_ERR_CLASS = 32'hFFFF_FFFF;

  // Input register fields
  localparam int IN0_START          = 0;
  localparam int IN0_DATA_SIGNED    = 3;
  localparam int IN1_SPLIT_HI       = 7;
  localparam int IN1_SPLIT_LO       = 0;
  localparam int IN1_SENSOR_BASE_HI = 15;
  localparam int IN1_SENSOR_BASE_LO = 8;
  localparam int IN3_OUT_FILE_HI    = 7;
  localparam int IN3_OUT_FILE_LO    = 0;

endpackage

// File: rtl/dsp_file_req_handshake.sv
// rtl/dsp_file_req_handshake.sv - request/acknowledge sequencer for one file access
// Ports: wb_clk, wb_rst (sync, active-high); go (access wanted, level);
//        file_active (file op in progress); req (hold request until active);
//        capture_en (read data valid this cycle); done (one-cycle, access complete).
module dsp_file_req_handshake
  import dsp_dtree_defs::*;
(
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic go,
  input  logic file_active,
  output logic req,
  output logic capture_en,
  output logic done
);

  hs_state_e state, state_nxt;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= H_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    capture_en = 1'b0;
    done       = 1'b0;
    case (state)
      H_IDLE: if (go) state_nxt = H_REQ;
      H_REQ: begin
        req = 1'b1;
        if (file_active) state_nxt = H_WAIT;
      end
      H_WAIT: begin
        // Request is already dropped; the file keeps data valid while active.
        capture_en = file_active;
        if (!file_active) begin
          done      = 1'b1;
          state_nxt = H_IDLE;
        end
      end
      default: state_nxt = H_IDLE;
    endcase
  end

endmodule

// File: rtl/dsp_equation_dtree_multi.sv
// rtl/dsp_equation_dtree_multi.sv - multi-sample decision-tree classifier over DSP files
// Ports: wb_clk, wb_rst (sync, active-high); equation_enable; dsp_input0..3_reg (config);
//        file_* (shared file interface); equation_done/interrupt (one-cycle pulses);
//        error (sticky until next start); dsp_output0_reg (last class); dsp_output1_reg (count).
module dsp_equation_dtree_multi
  import dsp_dtree_defs::*;
#(
  parameter int DW          = 32,
  parameter int MAX_DEPTH   = 8,
  parameter int NUM_SENSORS = 4
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          equation_enable,
  input  logic [DW-1:0] dsp_input0_reg,
  input  logic [DW-1:0] dsp_input1_reg,
  input  logic [DW-1:0] dsp_input2_reg,
  input  logic [DW-1:0] dsp_input3_reg,
  output logic [7:0]    file_num,
  output logic          file_read,
  output logic          file_write,
  output logic          file_reset,
  output logic [31:0]   file_rd_ptr_offset,
  output logic [31:0]   file_write_data,
  input  logic [31:0]   file_read_data,
  input  logic          file_active,
  output logic          equation_done,
  output logic          interrupt,
  output logic          error,
  output logic [31:0]   dsp_output0_reg,
  output logic [31:0]   dsp_output1_reg
);

  localparam int NODE_W  = $clog2(2 ** (MAX_DEPTH + 1));
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  dtree_state_e state, state_nxt;

  logic [NODE_W-1:0]  node;
  logic [DEPTH_W-1:0] depth;
  logic [DW-1:0]      sample_idx;
  logic               armed;
  logic [31:0]        split_val, ctrl_word, sensor_val, wr_word;

  logic hs_go, hs_req, hs_cap, hs_done;

  dsp_file_req_handshake u_hs (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .go          (hs_go),
    .file_active (file_active),
    .req         (hs_req),
    .capture_en  (hs_cap),
    .done        (hs_done)
  );

  logic       start_fire, data_signed, le, last_sample, is_leaf, bad_sel;
  logic [7:0] split_file, sensor_base, out_file, sensor_sel;
  logic [31:0] node_off;

  assign start_fire  = dsp_input0_reg[IN0_START] & equation_enable & armed;
  assign data_signed = dsp_input0_reg[IN0_DATA_SIGNED];
  assign split_file  = dsp_input1_reg[IN1_SPLIT_HI:IN1_SPLIT_LO];
  assign sensor_base = dsp_input1_reg[IN1_SENSOR_BASE_HI:IN1_SENSOR_BASE_LO];
  assign out_file    = dsp_input3_reg[IN3_OUT_FILE_HI:IN3_OUT_FILE_LO];
  assign sensor_sel  = ctrl_word[F_DSP_DTREE_SENSOR_SEL_HI:F_DSP_DTREE_SENSOR_SEL_LO];
  assign is_leaf     = ctrl_word[F_DSP_DTREE_LEAF];
  assign bad_sel     = {24'd0, sensor_sel} >= 32'(NUM_SENSORS);
  assign node_off    = (32'(node) - 32'd1) << 3;
  assign last_sample = !((sample_idx + DW'(1)) < dsp_input2_reg);
  assign le = data_signed ? ($signed(sensor_val) <= $signed(split_val)) : (sensor_val <= split_val);

  logic unused_bits;
  assign unused_bits = &{1'b0, sample_idx[DW-1:30], dsp_input0_reg[DW-1:4], dsp_input0_reg[2:1],
                         dsp_input1_reg[DW-1:16], dsp_input3_reg[DW-1:8],
                         ctrl_word[30:24], ctrl_word[15:8]};

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    hs_go              = 1'b0;
    file_num           = 8'd0;
    file_read          = 1'b0;
    file_write         = 1'b0;
    file_reset         = 1'b0;
    file_rd_ptr_offset = 32'd0;
    file_write_data    = 32'd0;
    equation_done      = 1'b0;
    interrupt          = 1'b0;
    case (state)
      S_IDLE: if (start_fire) state_nxt = (dsp_input2_reg == '0) ? S_RESET_SPLIT : S_RD_SPLIT;
      S_RD_SPLIT: begin
        hs_go              = 1'b1;
        file_read          = hs_req;
        file_num           = split_file;
        file_rd_ptr_offset = node_off;
        if (hs_done) state_nxt = S_RD_CTRL;
      end
      S_RD_CTRL: begin
        hs_go              = 1'b1;
        file_read          = hs_req;
        file_num           = split_file;
        file_rd_ptr_offset = node_off + 32'd4;
        if (hs_done) begin
          if (is_leaf)      state_nxt = S_WR_OUT;
          else if (bad_sel) state_nxt = S_ERR;
          else              state_nxt = S_RD_SENSOR;
        end
      end
      S_RD_SENSOR: begin
        hs_go              = 1'b1;
        file_read          = hs_req;
        file_num           = sensor_base + sensor_sel;
        file_rd_ptr_offset = {sample_idx[29:0], 2'b00};
        if (hs_done) state_nxt = S_COMPARE;
      end
      // The compare that would take depth to MAX_DEPTH has no node left to visit.
      S_COMPARE: state_nxt = (depth == DEPTH_W'(MAX_DEPTH - 1)) ? S_ERR : S_RD_SPLIT;
      S_ERR: state_nxt = S_WR_OUT;
      S_WR_OUT: begin
        hs_go           = 1'b1;
        file_write      = hs_req;
        file_num        = out_file;
        file_write_data = wr_word;
        if (hs_done) state_nxt = S_NEXT_SAMPLE;
      end
      S_NEXT_SAMPLE: state_nxt = last_sample ? S_RESET_SPLIT : S_RD_SPLIT;
      S_RESET_SPLIT: begin
        hs_go      = 1'b1;
        file_reset = hs_req;
        file_num   = split_file;
        if (hs_done) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        equation_done = 1'b1;
        interrupt     = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      node            <= NODE_W'(1);
      depth           <= '0;
      sample_idx      <= '0;
      armed           <= 1'b1;
      split_val       <= 32'd0;
      ctrl_word       <= 32'd0;
      sensor_val      <= 32'd0;
      wr_word         <= 32'd0;
      error           <= 1'b0;
      dsp_output0_reg <= 32'd0;
      dsp_output1_reg <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // Re-arm only after start is seen low so a held start cannot retrigger.
          if (start_fire) begin
            armed           <= 1'b0;
            error           <= 1'b0;
            dsp_output1_reg <= 32'd0;
            node            <= NODE_W'(1);
            depth           <= '0;
            sample_idx      <= '0;
          end else if (!dsp_input0_reg[IN0_START]) begin
            armed <= 1'b1;
          end
        end
        S_RD_SPLIT:  if (hs_cap) split_val <= file_read_data;
        S_RD_CTRL: begin
          if (hs_cap)  ctrl_word <= file_read_data;
          if (hs_done) wr_word   <= {24'd0, ctrl_word[F_DSP_DTREE_OUTPUT_HI:F_DSP_DTREE_OUTPUT_LO]};
        end
        S_RD_SENSOR: if (hs_cap) sensor_val <= file_read_data;
        S_COMPARE: begin
          node  <= {node[NODE_W-2:0], ~le};
          depth <= depth + 1'b1;
        end
        S_ERR: begin
          error   <= 1'b1;
          wr_word <= DSP_DTREE_ERR_CLASS;
        end
        S_WR_OUT: if (hs_done) begin
          dsp_output0_reg <= wr_word;
          dsp_output1_reg <= dsp_output1_reg + 32'd1;
        end
        S_NEXT_SAMPLE: if (!last_sample) begin
          sample_idx <= sample_idx + DW'(1);
          node       <= NODE_W'(1);
          depth      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_equation_dtree_multi.sv
// tb/tb_dsp_equation_dtree_multi.sv - directed self-checking bench for dsp_equation_dtree_multi
module tb_dsp_equation_dtree_multi;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        equation_enable;
  logic [31:0] dsp_input0_reg, dsp_input1_reg, dsp_input2_reg, dsp_input3_reg;
  logic [7:0]  file_num;
  logic        file_read, file_write, file_reset;
  logic [31:0] file_rd_ptr_offset, file_write_data, file_read_data;
  logic        file_active;
  logic        equation_done, interrupt, error;
  logic [31:0] dsp_output0_reg, dsp_output1_reg;

  dsp_equation_dtree_multi dut (
    .wb_clk             (wb_clk),
    .wb_rst             (wb_rst),
    .equation_enable    (equation_enable),
    .dsp_input0_reg     (dsp_input0_reg),
    .dsp_input1_reg     (dsp_input1_reg),
    .dsp_input2_reg     (dsp_input2_reg),
    .dsp_input3_reg     (dsp_input3_reg),
    .file_num           (file_num),
    .file_read          (file_read),
    .file_write         (file_write),
    .file_reset         (file_reset),
    .file_rd_ptr_offset (file_rd_ptr_offset),
    .file_write_data    (file_write_data),
    .file_read_data     (file_read_data),
    .file_active        (file_active),
    .equation_done      (equation_done),
    .interrupt          (interrupt),
    .error              (error),
    .dsp_output0_reg    (dsp_output0_reg),
    .dsp_output1_reg    (dsp_output1_reg)
  );

  initial forever #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] split_mem [0:1023];
  logic [31:0] sens_mem  [0:3][0:15];
  logic [31:0] wr_log[$];
  logic [31:0] rd_off[$];
  logic [31:0] rd_file[$];
  int          n_resets;
  int          busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] fn, input logic [31:0] off);
    if (fn == 8'd1) return split_mem[off[11:2]];
    if (fn >= 8'd4 && fn <= 8'd7) return sens_mem[int'(fn) - 4][off[5:2]];
    return 32'd0;
  endfunction

  // File responder: active for two cycles per request, data valid while active.
  initial begin
    file_active    = 1'b0;
    file_read_data = 32'd0;
    busy           = 0;
    n_resets       = 0;
    forever begin
      @(negedge wb_clk);
      if (busy > 0) begin
        busy--;
        if (busy == 0) file_active = 1'b0;
      end else if (file_read || file_write || file_reset) begin
        file_active = 1'b1;
        busy        = 2;
        if (file_read) begin
          file_read_data = model_read(file_num, file_rd_ptr_offset);
          rd_off.push_back(file_rd_ptr_offset);
          rd_file.push_back({24'd0, file_num});
        end
        if (file_write) wr_log.push_back(file_write_data);
        if (file_reset) n_resets++;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) split_mem[i] = 32'd0;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 16; j++) sens_mem[s][j] = 32'd0;
  endtask

  task automatic set_node(input int node, input logic [31:0] split, input logic [31:0] ctrl);
    split_mem[(node - 1) * 2]     = split;
    split_mem[(node - 1) * 2 + 1] = ctrl;
  endtask

  task automatic base_tree(input logic [31:0] root_split, input logic [7:0] sel);
    clear_mem();
    set_node(1, root_split, {8'd0, sel, 16'd0});
    set_node(2, 32'd0, 32'h8000_0007);
    set_node(3, 32'd0, 32'h8000_0009);
  endtask

  task automatic run(input logic [31:0] n, input logic sgn, input bit drop_en, input bit keep_start);
    int cyc;
    int pulses;
    wr_log.delete();
    rd_off.delete();
    rd_file.delete();
    n_resets        = 0;
    dsp_input2_reg  = n;
    dsp_input0_reg  = {28'd0, sgn, 2'b00, 1'b1};
    equation_enable = 1'b1;
    cyc    = 0;
    pulses = 0;
    while (cyc < 5000 && pulses == 0) begin
      @(posedge wb_clk); #1;
      cyc++;
      if (drop_en && cyc == 3) equation_enable = 1'b0;
      if (equation_done) begin
        pulses++;
        check("irq_with_done", {31'd0, interrupt}, 32'd1);
      end
    end
    check("done_seen", pulses, 32'd1);
    @(posedge wb_clk); #1;
    check("done_one_cycle", {30'd0, equation_done, interrupt}, 32'd0);
    equation_enable = 1'b1;
    if (!keep_start) begin
      dsp_input0_reg = 32'd0;
      @(posedge wb_clk); #1;
    end
  endtask

  initial begin
    int cyc;
    int extra;
    bit found;
    wb_rst          = 1'b1;
    equation_enable = 1'b0;
    dsp_input0_reg  = 32'd0;
    dsp_input1_reg  = 32'h0000_0401;
    dsp_input2_reg  = 32'd0;
    dsp_input3_reg  = 32'd9;
    clear_mem();
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_ctrl", {26'd0, file_read, file_write, file_reset, equation_done, interrupt, error}, 32'd0);
    check("rst_out0", dsp_output0_reg, 32'd0);
    check("rst_out1", dsp_output1_reg, 32'd0);
    check("rst_fnum", {24'd0, file_num}, 32'd0);
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;

    // Single sample, 50 <= 100 goes left to class 7
    base_tree(32'd100, 8'd0);
    sens_mem[0][0] = 32'd50;
    run(32'd1, 1'b0, 1'b0, 1'b0);
    check("t1_nwr", wr_log.size(), 32'd1);
    check("t1_wr0", wr_log[0], 32'd7);
    check("t1_out0", dsp_output0_reg, 32'd7);
    check("t1_out1", dsp_output1_reg, 32'd1);
    check("t1_nrd", rd_off.size(), 32'd5);
    check("t1_sens_file", rd_file[2], 32'd4);
    check("t1_node2_split_off", rd_off[3], 32'd8);
    check("t1_node2_ctrl_off", rd_off[4], 32'd12);
    check("t1_resets", n_resets, 32'd1);
    check("t1_err", {31'd0, error}, 32'd0);

    // Three samples, enable dropped mid-run
    sens_mem[0][0] = 32'd50;
    sens_mem[0][1] = 32'd150;
    sens_mem[0][2] = 32'd100;
    run(32'd3, 1'b0, 1'b1, 1'b0);
    check("t2_nwr", wr_log.size(), 32'd3);
    check("t2_wr0", wr_log[0], 32'd7);
    check("t2_wr1", wr_log[1], 32'd9);
    check("t2_wr2", wr_log[2], 32'd7);
    check("t2_soff0", rd_off[2], 32'd0);
    check("t2_soff1", rd_off[7], 32'd4);
    check("t2_soff2", rd_off[12], 32'd8);
    check("t2_out1", dsp_output1_reg, 32'd3);

    // Signed vs unsigned compare on sensor 1
    base_tree(32'd0, 8'd1);
    sens_mem[1][0] = 32'hFFFF_FFFE;
    run(32'd1, 1'b1, 1'b0, 1'b0);
    check("t3_signed_wr", wr_log[0], 32'd7);
    check("t3_sens_file", rd_file[2], 32'd5);
    run(32'd1, 1'b0, 1'b0, 1'b0);
    check("t3_unsigned_wr", wr_log[0], 32'd9);

    // Out-of-range sensor select, two samples
    base_tree(32'd0, 8'd5);
    run(32'd2, 1'b0, 1'b0, 1'b0);
    check("t4_err", {31'd0, error}, 32'd1);
    check("t4_nwr", wr_log.size(), 32'd2);
    check("t4_wr0", wr_log[0], 32'hFFFF_FFFF);
    check("t4_wr1", wr_log[1], 32'hFFFF_FFFF);
    check("t4_nrd", rd_off.size(), 32'd4);
    check("t4_out0", dsp_output0_reg, 32'hFFFF_FFFF);
    check("t4_out1", dsp_output1_reg, 32'd2);

    // Leafless chain: nodes 1,2,4..128 visited, then depth error
    clear_mem();
    run(32'd1, 1'b0, 1'b0, 1'b0);
    check("t5_err", {31'd0, error}, 32'd1);
    check("t5_nrd", rd_off.size(), 32'd24);
    check("t5_last_split_off", rd_off[21], 32'd1016);
    check("t5_wr0", wr_log[0], 32'hFFFF_FFFF);

    // Held start must not retrigger; error cleared by new start
    base_tree(32'd100, 8'd0);
    sens_mem[0][0] = 32'd50;
    run(32'd1, 1'b0, 1'b0, 1'b1);
    check("t6_err_cleared", {31'd0, error}, 32'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge wb_clk); #1;
      if (equation_done || file_read || file_write || file_reset) extra++;
    end
    check("t6_no_retrigger", extra, 32'd0);
    check("t6_nwr_held", wr_log.size(), 32'd1);
    dsp_input0_reg = 32'd0;
    @(posedge wb_clk); #1;
    run(32'd1, 1'b0, 1'b0, 1'b0);
    check("t6_rerun_wr", wr_log.size(), 32'd1);
    check("t6_rerun_out0", dsp_output0_reg, 32'd7);

    // N = 0
    run(32'd0, 1'b0, 1'b0, 1'b0);
    check("t8_nwr", wr_log.size(), 32'd0);
    check("t8_nrd", rd_off.size(), 32'd0);
    check("t8_out1", dsp_output1_reg, 32'd0);

    // Reset during the sensor read
    dsp_input2_reg  = 32'd1;
    dsp_input0_reg  = 32'd1;
    equation_enable = 1'b1;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < 500) begin
      @(posedge wb_clk); #1;
      cyc++;
      if (file_read && file_num == 8'd4) found = 1'b1;
    end
    check("t7_reached_sensor", {31'd0, found}, 32'd1);
    wb_rst         = 1'b1;
    dsp_input0_reg = 32'd0;
    @(posedge wb_clk); #1;
    check("t7_ctrl", {26'd0, file_read, file_write, file_reset, equation_done, interrupt, error}, 32'd0);
    check("t7_fnum", {24'd0, file_num}, 32'd0);
    check("t7_off", file_rd_ptr_offset, 32'd0);
    check("t7_out0", dsp_output0_reg, 32'd0);
    wb_rst = 1'b0;
    repeat (6) @(posedge wb_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
